csla_serial_add_ctrl: RTL and testbench
=======================================

# csla_serial_add_ctrl

Multi-cycle controller that time-shares a single 4-bit carry-select adder slice (2-bit ripple low half, 2-bit ripple plus BEC high half, mux selected by low-half carry) to add or subtract two WIDTH-bit operands, one nibble per clock. It sits between an operand source and a result sink, such as the partial-product accumulation stage of the Karatsuba multiplier. It trades latency for area against the fully unrolled sqrt-CSLA. Both sides use valid/ready handshakes.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of 4 and at least 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operands and control are valid.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  1 = compute a - b (b inverted, carry-in forced to 1).
- out_valid  output  1  result is valid.
- out_ready  input  1  sink accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Reset (rst_n=0 at a clock edge): state=IDLE; in_ready=0 during the reset cycle and 1 afterwards; out_valid=0; sum=0; cout=0; ovf=0; nibble counter=0; carry register=0. Any in-flight operation is discarded.
- N = WIDTH/4 nibbles. The counter is ceil(log2(N+1)) bits wide and always counts from 0 to N-1 with no wrap.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a and b_eff = sub ? ~b : b. Set the carry register to sub ? 1 : cin. Latch the MSBs of a and b_eff. Clear the counter and go to RUN.
  - RUN: in_ready=0. Each cycle, feed nibble k of a and b_eff, plus the carry register, to the slice. Write the slice sum into sum[4k+3:4k] and the slice carry-out into the carry register. Increment k. When k=N-1 is processed, go to DONE.
  - DONE: out_valid=1. cout = final carry. ovf = (a_msb==b_eff_msb) && (sum[WIDTH-1]!=a_msb). On out_ready, go to IDLE.
- The slice is the 4-bit carry-select slice described in the summary. The controller instantiates exactly one slice; there is no other adder.
- sum, cout and ovf hold their values while out_valid=1 and out_ready=0. They keep the last result after returning to IDLE until the next accept overwrites them nibble by nibble.
- Inputs are sampled only at the accept edge. Changes on a, b, cin and sub at any other time have no effect.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Arithmetic is modulo 2^WIDTH. Carry beyond the MSB appears only on cout.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..N; nibble k is written at the end of cycle k+1.
- out_valid rises in cycle N+1, i.e. latency N+1 clocks from accept to result valid (5 for WIDTH=16).
- Result handshake completes on the first edge in DONE with out_ready=1. IDLE (in_ready=1) follows on the next cycle.
- Minimum initiation interval is N+2 cycles, with out_ready held high. There is no overlap between back-to-back operations.
- in_ready and out_valid are never high in the same cycle.
- Reset dominates every state. Reset asserted during RUN or DONE yields IDLE outputs on the following cycle, with no out_valid pulse.

## Test plan
- Add: WIDTH=16, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0, out_valid first high exactly 5 cycles after accept.
- Carry chain: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1. Subtract a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Subtract with borrow: sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0.
- Backpressure and back-to-back: hold out_ready=0 for 3 cycles in DONE -> sum, cout, ovf and out_valid stable, in_ready=0. With in_valid held high, the second operation is accepted exactly N+2 cycles after the first.
- Reset mid-run: assert rst_n=0 in cycle 2 after accept -> next cycle out_valid=0, sum=0, state IDLE. A new operation 0x0001+0x0001 then gives 0x0002 with normal latency.

Source files
------------

// File: rtl/csla_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csla_serial_add_ctrl (with csla4_slice)
// Brief    : Nibble-serial add/subtract controller built around one 4-bit
//            carry-select adder slice, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================

module csla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic w_c1, w_c2;
    logic w_h0, w_h1, w_hc1, w_hc2;
    logic w_e0, w_e1, w_ec;

    // Low half: 2-bit ripple from the incoming carry
    assign sum[0] = a[0] ^ b[0] ^ cin;
    assign w_c1   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
    assign sum[1] = a[1] ^ b[1] ^ w_c1;
    assign w_c2   = (a[1] & b[1]) | (w_c1 & (a[1] ^ b[1]));

    // High half: ripple assuming carry 0, BEC supplies the carry-1 variant
    assign w_h0  = a[2] ^ b[2];
    assign w_hc1 = a[2] & b[2];
    assign w_h1  = a[3] ^ b[3] ^ w_hc1;
    assign w_hc2 = (a[3] & b[3]) | (w_hc1 & (a[3] ^ b[3]));

    assign w_e0 = ~w_h0;
    assign w_e1 = w_h1 ^ w_h0;
    assign w_ec = w_hc2 | (w_h1 & w_h0);

    assign sum[3:2] = w_c2 ? {w_e1, w_e0} : {w_h1, w_h0};
    assign cout     = w_c2 ? w_ec : w_hc2;
endmodule

module csla_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int c_n     = WIDTH / 4;
    localparam int c_cnt_w = $clog2(c_n + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_a, r_b, r_sum;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry, r_a_msb, r_b_msb, r_cout, r_ovf;
    logic [WIDTH-1:0]   w_b_eff;
    logic [3:0]         w_slice_sum;
    logic               w_slice_co;
    logic               w_last;

    assign w_b_eff = sub ? ~b : b;
    assign w_last  = (r_cnt == c_last);

    csla4_slice u_slice (
        .a    (r_a[3:0]),
        .b    (r_b[3:0]),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (in_valid)  w_state_nxt = c_run;
            c_run:   if (w_last)    w_state_nxt = c_done;
            c_done:  if (out_ready) w_state_nxt = c_idle;
            default:                w_state_nxt = c_idle;
        endcase
    end

    // Operands shift right so the slice always sees the current nibble at [3:0]
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_eff;
                        r_carry <= sub ? 1'b1 : cin;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= w_b_eff[WIDTH-1];
                        r_cnt   <= '0;
                    end
                end
                c_run: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_carry <= w_slice_co;
                    for (int j = 0; j < c_n; j++) begin
                        if (r_cnt == c_cnt_w'(j)) r_sum[j*4 +: 4] <= w_slice_sum;
                    end
                    if (w_last) begin
                        r_cout <= w_slice_co;
                        r_ovf  <= (r_a_msb == r_b_msb) && (w_slice_sum[3] != r_a_msb);
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == c_idle);
    assign out_valid = (r_state == c_done);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_csla_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csla_serial_add_ctrl
// Brief    : Self-checking bench, directed corner cases plus random operations
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_csla_serial_add_ctrl;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    csla_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mci, input logic msub);
        int ua, ub, sa, sb, ur, sr;
        logic c, o;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            ur = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            ur = ua + ub + int'(mci);
            sr = sa + sb + int'(mci);
            c  = (ur > 65535);
        end
        o = (sr > 32767) || (sr < -32768);
        return {o, c, ur[15:0]};
    endfunction

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                          input logic tsub, input int hold);
        logic [17:0] e;
        int n;
        e = model(ta, tb, tci, tsub);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", in_ready, 1);
        a = ta; b = tb; cin = tci; sub = tsub; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, N + 1);
        check("sum", sum, e[15:0]);
        check("cout", cout, e[16]);
        check("ovf", ovf, e[17]);
        check("in_ready_in_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {in_ready, out_valid}, 2'b01);
            check("hold_result", {ovf, cout, sum}, e);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("back_to_idle", {in_ready, out_valid}, 2'b10);
        check("result_kept", {ovf, cout, sum}, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc[$];
        int res;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", {ovf, cout, sum}, 18'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 3);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);

        // Back-to-back with in_valid and out_ready held high
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        res = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) acc.push_back(t);
            if (out_valid) begin
                check("b2b_sum", sum, 16'h3333);
                res++;
            end
        end
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
        check("b2b_results", res >= 2, 1);
        check("b2b_accepts", acc.size() >= 2, 1);
        if (acc.size() >= 2) check("b2b_interval", acc[1] - acc[0], N + 2);

        // Reset in cycle 2 after accept
        a = 16'hABCD; b = 16'h1357; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_result", {ovf, cout, sum}, 18'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", {in_ready, out_valid}, 2'b10);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

        for (int k = 0; k < 30; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
